// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calc_unit slice.
//   op_e    - request operation encoding (ADD, SUB, MUL, DIV)
//   state_e - calc_unit control states
//   OPW/RESW/SOPW/ITER - operand, result, short-operand widths and the
//                        iteration count of the MUL/DIV datapath
package calc_pkg;

  localparam int OPW  = 15;
  localparam int RESW = 16;
  localparam int SOPW = 7;
  localparam int ITER = 7;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/calc_iter.sv
// calc_iter: iterative 7x7 multiplier (shift-add) and 7/7 divider
// (restoring), one bit per cycle.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_start        - load operands and begin ITER steps
//   i_op           - OP_MUL selects multiply, OP_DIV selects divide
//   i_a, i_b       - 7-bit operands (divisor assumed nonzero)
//   o_busy         - more than the current step still remains
//   o_result       - zero-extended product or quotient, held after the run
module calc_iter
  import calc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  op_e             i_op,
  input  logic [SOPW-1:0] i_a,
  input  logic [SOPW-1:0] i_b,
  output logic            o_busy,
  output logic [RESW-1:0] o_result
);

  logic                r_run;
  logic                r_div;
  logic [2:0]          r_cnt;
  logic [2*SOPW-1:0]   r_acc;
  logic [2*SOPW-1:0]   r_mcand;
  logic [SOPW-1:0]     r_mplier;
  logic [SOPW-1:0]     r_rem;
  logic [SOPW-1:0]     r_quo;
  logic [SOPW-1:0]     r_dvs;

  logic [SOPW:0]       w_trial;
  logic                w_ge;
  logic [SOPW-1:0]     w_rem_next;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits.
  assign w_trial    = {r_rem, r_quo[SOPW-1]};
  assign w_ge       = (w_trial >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? SOPW'(w_trial - {1'b0, r_dvs}) : w_trial[SOPW-1:0];

  // Busy drops during the last step so the controller leaves EXEC on the
  // same edge that completes the final bit.
  assign o_busy   = r_run && (r_cnt != 3'd0);
  assign o_result = r_div ? {{(RESW-SOPW){1'b0}}, r_quo}
                          : {{(RESW-2*SOPW){1'b0}}, r_acc};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_div    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_div    <= (i_op == OP_DIV);
      r_cnt    <= 3'(ITER - 1);
      r_acc    <= '0;
      r_mcand  <= {{SOPW{1'b0}}, i_a};
      r_mplier <= i_b;
      r_rem    <= '0;
      r_quo    <= i_a;
      r_dvs    <= i_b;
    end else if (r_run) begin
      if (r_cnt == 3'd0) r_run <= 1'b0;
      else               r_cnt <= r_cnt - 3'd1;
      if (r_div) begin
        r_rem <= w_rem_next;
        r_quo <= {r_quo[SOPW-2:0], w_ge};
      end else begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/calc_unit.sv
// calc_unit: ADD/SUB/MUL/DIV request-response unit.
//   i_clk, i_rst_n             - clock, async active-low reset
//   i_req_valid/o_req_ready    - request handshake
//   i_req_op, i_req_a, i_req_b - operation and 15-bit operands
//   o_rsp_valid/i_rsp_ready    - response handshake
//   o_rsp_result, o_rsp_err    - 16-bit result, divide-by-zero flag
//
// state   | meaning
// IDLE    | ready for a request
// EXEC    | calc_iter running a 7-step MUL/DIV
// DONE    | response presented, waiting for i_rsp_ready
module calc_unit
  import calc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [OPW-1:0]  i_req_a,
  input  logic [OPW-1:0]  i_req_b,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [RESW-1:0] o_rsp_result,
  output logic            o_rsp_err
);

  state_e          r_state;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [RESW-1:0] r_result;
  logic            r_err;
  logic            r_sel_iter;

  op_e             w_op;
  logic            w_accept;
  logic            w_b_zero;
  logic            w_iter_op;
  logic            w_start;
  logic            w_iter_busy;
  logic [RESW-1:0] w_iter_result;

  assign w_op      = op_e'(i_req_op);
  assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
  assign w_b_zero  = (i_req_b[SOPW-1:0] == '0);
  assign w_iter_op = (w_op == OP_MUL) || ((w_op == OP_DIV) && !w_b_zero);
  assign w_start   = w_accept && w_iter_op;

  calc_iter u_iter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_start),
    .i_op     (w_op),
    .i_a      (i_req_a[SOPW-1:0]),
    .i_b      (i_req_b[SOPW-1:0]),
    .o_busy   (w_iter_busy),
    .o_result (w_iter_result)
  );

  // The iterative result is held in calc_iter's registers after the run,
  // so selecting it here stays stable for the whole DONE phase.
  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_err    = r_err;
  assign o_rsp_result = r_sel_iter ? w_iter_result : r_result;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_sel_iter  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_sel_iter  <= w_iter_op;
            r_err       <= (w_op == OP_DIV) && w_b_zero;
            case (w_op)
              OP_ADD:  r_result <= {1'b0, i_req_a} + {1'b0, i_req_b};
              OP_SUB:  r_result <= {1'b0, i_req_a} - {1'b0, i_req_b};
              default: r_result <= '1;
            endcase
            if (w_iter_op) begin
              r_state <= ST_EXEC;
            end else begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (!w_iter_busy) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_unit.sv
// tb_calc_unit: directed and random checks of calc_unit against an
// arithmetic reference model.
module tb_calc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [14:0] req_a = '0;
  logic [14:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calc_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operation's rules.
  function automatic void ref_model(input int op, input int a, input int b,
                                    output int res, output int err, output int lat);
    int a7, b7;
    a7 = a % 128;
    b7 = b % 128;
    err = 0;
    lat = 1;
    case (op)
      0: res = a + b;
      1: res = (a - b + 65536) % 65536;
      2: begin res = a7 * b7; lat = 8; end
      default: begin
        if (b7 == 0) begin res = 65535; err = 1; end
        else begin res = a7 / b7; lat = 8; end
      end
    endcase
  endfunction

  task automatic junk_inputs();
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 2'($urandom);
    req_a     = 15'($urandom);
    req_b     = 15'($urandom);
  endtask

  task automatic run(input int op, input int a, input int b, input int hold, input string tag);
    int res, err, lat;
    ref_model(op, a, b, res, err, lat);
    chk({tag, ".ready_idle"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op[1:0];
    req_a     = a[14:0];
    req_b     = b[14:0];
    step();
    for (int n = 1; n <= lat; n++) begin
      chk({tag, ".valid_lat"}, 32'(rsp_valid), 32'(n == lat));
      chk({tag, ".ready_busy"}, 32'(req_ready), 0);
      junk_inputs();
      if (n < lat) begin
        rsp_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    chk({tag, ".result"}, 32'(rsp_result), res);
    chk({tag, ".err"}, 32'(rsp_err), err);
    for (int k = 0; k < hold; k++) begin
      rsp_ready = 1'b0;
      junk_inputs();
      step();
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".hold_result"}, 32'(rsp_result), res);
      chk({tag, ".hold_err"}, 32'(rsp_err), err);
      chk({tag, ".hold_ready"}, 32'(req_ready), 0);
    end
    // A request offered on the handshake edge must not be taken.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, ".post_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".post_ready"}, 32'(req_ready), 1);
  endtask

  initial begin
    int op, a, b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 1);
    chk("rst.valid", 32'(rsp_valid), 0);
    chk("rst.result", 32'(rsp_result), 0);
    chk("rst.err", 32'(rsp_err), 0);
    rst_n = 1'b1;

    run(0, 32767, 32767, 0, "add_max");
    run(1, 5, 9, 1, "sub_wrap");
    run(1, 0, 1, 0, "sub_zero_minus_one");
    run(2, 127 + (8'h55 << 7), 127 + (8'h03 << 7), 0, "mul_max");
    run(3, 100, 7, 0, "div_100_7");
    run(3, 9, 0, 0, "div_zero");
    run(3, 9, 128 * 5, 2, "div_zero_high_bits");
    run(2, 0, 99, 5, "mul_backpressure");

    // Reset in the third cycle of a MUL abandons it with no response.
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_a     = 15'd127;
    req_b     = 15'd127;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst.ready", 32'(req_ready), 1);
    chk("midrst.valid", 32'(rsp_valid), 0);
    chk("midrst.result", 32'(rsp_result), 0);
    chk("midrst.err", 32'(rsp_err), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("midrst.no_rsp", 32'(rsp_valid), 0);
    end
    run(0, 1234, 4321, 0, "add_after_reset");

    for (int t = 0; t < 220; t++) begin
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, 32767);
      b  = $urandom_range(0, 32767);
      if ($urandom_range(0, 7) == 0) b = b & 32'h7F80;
      run(op, a, b, $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_unit.md
CALC_UNIT -- requirements
Module: calc_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be synchronous to clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  high when a request is presented.
REQ-005 req_ready  output  1  high when the block can accept a request.
REQ-006 req_op  input  2  operation select: 0=ADD, 1=SUB, 2=MUL, 3=DIV.
REQ-007 req_a  input  15  operand A; MUL and DIV use only bits [6:0].
REQ-008 req_b  input  15  operand B; MUL and DIV use only bits [6:0].
REQ-009 rsp_valid  output  1  high when a result is presented.
REQ-010 rsp_ready  input  1  high when the consumer accepts a result.
REQ-011 rsp_result  output  16  result of the operation.
REQ-012 rsp_err  output  1  divide-by-zero flag, valid while rsp_valid is high.

Function
REQ-013 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high; op and operands SHALL be captured at that edge.
REQ-014 The state machine SHALL have states IDLE, EXEC and DONE; req_ready SHALL be high only in IDLE.
REQ-015 IDLE SHALL go to DONE on acceptance of ADD, SUB, or DIV with b[6:0]=0; it SHALL go to EXEC on acceptance of MUL, or of DIV with b[6:0]!=0.
REQ-016 ADD SHALL give zero-extended a+b in 16 bits; no overflow is possible.
REQ-017 SUB SHALL give (a-b) modulo 2^16 using zero-extended operands, so a<b wraps (example: 0-1 gives 16'hFFFF).
REQ-018 MUL SHALL give the 14-bit product of a[6:0] and b[6:0], zero-extended, computed shift-add at one bit per cycle.
REQ-019 DIV SHALL give the 7-bit quotient of a[6:0]/b[6:0], zero-extended, computed by restoring division at one bit per cycle; the remainder SHALL be discarded.
REQ-020 EXEC SHALL last exactly 7 cycles, tracked by a 3-bit counter, and SHALL then go to DONE.
REQ-021 Latency from acceptance edge to first cycle with rsp_valid high SHALL be 1 cycle for ADD/SUB/DIV-by-zero and 8 cycles for MUL/DIV.
REQ-022 DIV with b[6:0]=0 SHALL return rsp_result=16'hFFFF and rsp_err=1; in every other case rsp_err SHALL be 0.
REQ-023 In DONE, rsp_valid SHALL be high, and rsp_result and rsp_err SHALL hold stable until rsp_ready is sampled high.
REQ-024 On a DONE edge with rsp_ready high, the block SHALL go to IDLE; a new request SHALL NOT be accepted on that same edge.
REQ-025 rsp_valid SHALL be low in IDLE and EXEC.
REQ-026 req_valid and operand changes during EXEC or DONE SHALL have no effect.
REQ-027 Operand bits [14:7] SHALL be ignored for MUL and DIV.

Reset
REQ-028 While rst_n is low, the state SHALL be IDLE, and req_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, and the counter and all datapath registers SHALL be 0.
REQ-029 Reset asserted during EXEC or DONE SHALL abandon the operation immediately, with no response emitted.
REQ-030 After rst_n is released, the first edge SHALL be able to accept a request.

Structure
REQ-031 A shared package calc_pkg SHALL hold the op enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the state enum, and the constants OPW=15, RESW=16, SOPW=7 and ITER=7.
REQ-032 The iterative MUL/DIV datapath SHALL be a sub-module calc_iter, with ports start, op, a, b, busy, result, driven by the calc_unit FSM.

Verification
REQ-033 Reset-then-ADD: ADD a=32767, b=32767 -> rsp_result=65534, rsp_err=0, rsp_valid one cycle after acceptance.
REQ-034 SUB wrap: SUB a=5, b=9 -> rsp_result=16'hFFFC.
REQ-035 MUL: MUL a=127, b=127 with a[14:7] nonzero -> rsp_result=16129 after 8 cycles, with req_ready low throughout.
REQ-036 DIV: DIV a=100, b=7 -> rsp_result=14 after 8 cycles; DIV a=9, b=0 -> rsp_result=16'hFFFF and rsp_err=1 after 1 cycle.
REQ-037 Backpressure: hold rsp_ready low for 5 cycles in DONE -> result stays stable and no new acceptance occurs; the next request is accepted no earlier than 1 cycle after the response handshake.
REQ-038 Reset mid-operation: assert rst_n low in cycle 3 of a MUL -> all outputs at reset values, no response; the next ADD completes normally.
REQ-039 The bench SHALL run at least 200 random requests under random backpressure and compare each against a reference model, with zero mismatches required.
